detection_counter: RTL and testbench
====================================

# detection_counter

Downstream stage of the Moore and Mealy sequence detectors. It counts the single-cycle detection pulses from both detectors over one stimulus frame, where a frame is one `data_valid` burst plus a drain window. At the end of the frame it presents both counts, a mismatch flag and a saturation flag on a valid/ready report interface. It replaces ad-hoc bench counters with a checkable, synthesizable block.

## Interface
Parameters:
- `COUNT_WIDTH`, default 16: width of each detection counter.
- `DRAIN_CYCLES`, default 2: cycles counted after `data_valid` falls, to absorb the registered Moore output lag. Legal range 1..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `data_valid`  in  1: frame qualifier from the stimulus generator.
- `moore_detected`  in  1: Moore detector pulse.
- `mealy_detected`  in  1: Mealy detector pulse.
- `report_valid`  out  1: report available.
- `report_ready`  in  1: consumer accepts the report.
- `moore_count`  out  COUNT_WIDTH: Moore detections in the frame.
- `mealy_count`  out  COUNT_WIDTH: Mealy detections in the frame.
- `mismatch`  out  1: `moore_count != mealy_count`.
- `saturated`  out  1: either counter hit all-ones during the frame.
- `frame_lost`  out  1: sticky; a frame started while a report was pending.

## Operation
- FSM states: IDLE, COUNT, DRAIN, REPORT. Reset state is IDLE.
- IDLE
  - Counts, `saturated` and `frame_lost` hold their last values.
  - On `data_valid`=1: clear both counters, `saturated` and `frame_lost`; go to COUNT.
  - A detection pulse in this same cycle is counted, so counters load 1 instead of 0.
- COUNT
  - Each cycle, `moore_detected`=1 increments the Moore counter and `mealy_detected`=1 increments the Mealy counter. Both may increment in the same cycle.
  - On `data_valid`=0: go to DRAIN and load the drain counter with DRAIN_CYCLES-1. That cycle's pulses are still counted.
- DRAIN
  - Counting continues.
  - `data_valid`=1 returns to COUNT with no clear; the frame continues.
  - When the drain counter reaches 0: go to REPORT.
- REPORT
  - `report_valid`=1. All report outputs are held stable.
  - Detection inputs are ignored.
  - On `report_valid && report_ready`: go to IDLE.
  - If `data_valid`=1 in any REPORT cycle, set internal `lost_pending`. On return to IDLE it loads into `frame_lost` after the IDLE clear. A frame in progress at handshake is therefore entered mid-burst and flagged.
- Counters saturate at 2^COUNT_WIDTH-1 and never wrap. An increment attempted at all-ones sets `saturated`.
- `mismatch` is combinational from the registered counts. It is meaningful only while `report_valid`=1.

## Timing
- Reset values:
  - `report_valid`=0, counts=0, `mismatch`=0, `saturated`=0, `frame_lost`=0.
  - FSM=IDLE.
- Latency:
  - The last `data_valid`=1 cycle is edge N.
  - DRAIN occupies edges N+1 .. N+DRAIN_CYCLES.
  - `report_valid` rises after edge N+DRAIN_CYCLES+1.
- Handshake:
  - `report_valid` is never deasserted before acceptance.
  - When `report_ready` is held at 1, acceptance happens in the first REPORT cycle, and IDLE follows at the next edge.
- Reset asserted mid-frame immediately clears all state and outputs. No partial report is issued.

## Configuration
- Macro `DETECTION_COUNTER_FRAME_LEN_EN`.
- When defined:
  - Adds output `frame_len`, COUNT_WIDTH bits: the number of `data_valid`=1 cycles in the frame.
  - It saturates and contributes to `saturated`.
  - It is cleared and held with the other counts. Reset value 0.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

## Structure
- Package `detection_counter_pkg` contains:
  - The state enum `dc_state_t` (IDLE, COUNT, DRAIN, REPORT).
  - Default constants `DC_COUNT_WIDTH`=16 and `DC_DRAIN_CYCLES`=2.
- Sub-module `sat_counter`:
  - Parameters: WIDTH.
  - Ports: `clk`, `reset`, `clear`, `inc`, `hold` in; `count`, `sat` out.
  - Instantiated twice, or three times with the macro.

## Test plan
- One frame of 20 valid cycles, with 3 Moore pulses and 3 Mealy pulses where the last Moore pulse falls 1 cycle after `data_valid` falls -> report with counts 3/3, `mismatch`=0, `report_valid` rising at edge N+3.
- Counts 2 Moore vs 1 Mealy, with `report_ready` held 0 for 5 cycles -> `report_valid`=1 and outputs stable for all 5 cycles, `mismatch`=1, then IDLE one edge after `report_ready`=1.
- COUNT_WIDTH=3 with 9 Moore pulses -> `moore_count`=7, `saturated`=1, no wrap.
- `data_valid` drops for 1 cycle and then returns (DRAIN_CYCLES=2) -> single frame, counts accumulate with no intermediate report.
- `data_valid` rises while REPORT is pending -> next report shows `frame_lost`=1.
- `reset` pulsed mid-COUNT after 4 pulses -> all outputs 0 asynchronously, no `report_valid`. With the macro defined, also check `frame_len`=20 for the first scenario.

Source files
------------

// File: rtl/detection_counter_pkg.sv
// Shared types and default constants for the detection_counter block.
package detection_counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } dc_state_t;

  localparam int DC_COUNT_WIDTH  = 16;
  localparam int DC_DRAIN_CYCLES = 2;

endpackage

// File: rtl/detection_counter_sat_counter.sv
// Saturating event counter with a sticky overflow-attempt flag.
// The clear input loads the current increment, so a pulse coincident with clear counts as 1.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_r;
  logic             sat_r;
  logic             at_max_s;

  assign at_max_s = &count_r;

  // Count register: clear wins over hold; increments at all-ones set the flag instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      sat_r   <= 1'b0;
    end else if (clear) begin
      count_r <= WIDTH'(inc);
      sat_r   <= 1'b0;
    end else if (inc && !hold) begin
      if (at_max_s) begin
        sat_r <= 1'b1;
      end else begin
        count_r <= count_r + WIDTH'(1);
      end
    end
  end

  assign count = count_r;
  assign sat   = sat_r;

endmodule

// File: rtl/detection_counter.sv
// Counts Moore/Mealy detection pulses over one frame and reports them via valid/ready.
// Optional frame-length counter enabled by DETECTION_COUNTER_FRAME_LEN_EN.
module detection_counter
  import detection_counter_pkg::*;
#(
  parameter int COUNT_WIDTH  = DC_COUNT_WIDTH,
  parameter int DRAIN_CYCLES = DC_DRAIN_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_valid,
  input  logic                   moore_detected,
  input  logic                   mealy_detected,
  output logic                   report_valid,
  input  logic                   report_ready,
  output logic [COUNT_WIDTH-1:0] moore_count,
  output logic [COUNT_WIDTH-1:0] mealy_count,
  output logic                   mismatch,
  output logic                   saturated,
`ifdef DETECTION_COUNTER_FRAME_LEN_EN
  output logic [COUNT_WIDTH-1:0] frame_len,
`endif
  output logic                   frame_lost
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  dc_state_t  state_r;
  dc_state_t  state_nx_s;
  logic [3:0] drain_r;
  logic       lost_pending_r;
  logic       frame_lost_r;
  logic       clear_s;
  logic       hold_s;
  logic       sat_moore_s;
  logic       sat_mealy_s;
  logic       sat_len_s;

  assign clear_s = (state_r == IDLE) && data_valid;
  assign hold_s  = !((state_r == COUNT) || (state_r == DRAIN));

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (data_valid) state_nx_s = COUNT;
        else            state_nx_s = IDLE;
      end
      COUNT: begin
        if (!data_valid) state_nx_s = DRAIN;
        else             state_nx_s = COUNT;
      end
      DRAIN: begin
        if (data_valid)              state_nx_s = COUNT;
        else if (drain_r == 4'd0)    state_nx_s = REPORT;
        else                         state_nx_s = DRAIN;
      end
      REPORT: begin
        if (report_ready) state_nx_s = IDLE;
        else              state_nx_s = REPORT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Drain timer: reloaded each time data_valid drops so a resumed burst restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_r <= 4'd0;
    end else if ((state_r == COUNT) && !data_valid) begin
      drain_r <= DRAIN_LOAD;
    end else if ((state_r == DRAIN) && (drain_r != 4'd0)) begin
      drain_r <= drain_r - 4'd1;
    end
  end

  // A burst seen while the report waits is remembered and flagged on the next frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lost_pending_r <= 1'b0;
      frame_lost_r   <= 1'b0;
    end else if (clear_s) begin
      frame_lost_r   <= lost_pending_r;
      lost_pending_r <= 1'b0;
    end else if ((state_r == REPORT) && data_valid) begin
      lost_pending_r <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_moore_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .inc   (moore_detected),
    .hold  (hold_s),
    .count (moore_count),
    .sat   (sat_moore_s)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_mealy_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .inc   (mealy_detected),
    .hold  (hold_s),
    .count (mealy_count),
    .sat   (sat_mealy_s)
  );

`ifdef DETECTION_COUNTER_FRAME_LEN_EN
  sat_counter #(.WIDTH(COUNT_WIDTH)) u_len_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .inc   (data_valid),
    .hold  (hold_s),
    .count (frame_len),
    .sat   (sat_len_s)
  );
`else
  assign sat_len_s = 1'b0;
`endif

  assign report_valid = (state_r == REPORT);
  assign mismatch     = (moore_count != mealy_count);
  assign saturated    = sat_moore_s | sat_mealy_s | sat_len_s;
  assign frame_lost   = frame_lost_r;

endmodule

// File: tb/tb_detection_counter.sv
// Scoreboard bench for detection_counter: default 16-bit instance plus a 3-bit instance for saturation.
module tb_detection_counter;
  import detection_counter_pkg::*;

  localparam int DRAIN = 2;

  logic clk = 1'b0;
  logic reset, data_valid, moore_detected, mealy_detected, report_ready;
  logic        report_valid, mismatch, saturated, frame_lost;
  logic [15:0] moore_count, mealy_count;
  logic        rv3, mism3, sat3, lost3;
  logic [2:0]  mo3, me3;
`ifdef DETECTION_COUNTER_FRAME_LEN_EN
  logic [15:0] frame_len;
  logic [2:0]  flen3;
`endif

  typedef struct {
    logic [15:0] mo, me, flen;
    logic        mism, sat, lost;
    logic [2:0]  mo3, me3, flen3;
    logic        sat3;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  detection_counter #(.COUNT_WIDTH(16), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .data_valid(data_valid),
    .moore_detected(moore_detected), .mealy_detected(mealy_detected),
    .report_valid(report_valid), .report_ready(report_ready),
    .moore_count(moore_count), .mealy_count(mealy_count),
    .mismatch(mismatch), .saturated(saturated),
`ifdef DETECTION_COUNTER_FRAME_LEN_EN
    .frame_len(frame_len),
`endif
    .frame_lost(frame_lost)
  );

  detection_counter #(.COUNT_WIDTH(3), .DRAIN_CYCLES(DRAIN)) dut3 (
    .clk(clk), .reset(reset), .data_valid(data_valid),
    .moore_detected(moore_detected), .mealy_detected(mealy_detected),
    .report_valid(rv3), .report_ready(report_ready),
    .moore_count(mo3), .mealy_count(me3),
    .mismatch(mism3), .saturated(sat3),
`ifdef DETECTION_COUNTER_FRAME_LEN_EN
    .frame_len(flen3),
`endif
    .frame_lost(lost3)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_report(input exp_t e);
    check_value("report_valid", 32'(report_valid), 32'd1);
    check_value("moore_count", 32'(moore_count), 32'(e.mo));
    check_value("mealy_count", 32'(mealy_count), 32'(e.me));
    check_value("mismatch", 32'(mismatch), 32'(e.mism));
    check_value("saturated", 32'(saturated), 32'(e.sat));
    check_value("frame_lost", 32'(frame_lost), 32'(e.lost));
    check_value("w3_report_valid", 32'(rv3), 32'd1);
    check_value("w3_moore_count", 32'(mo3), 32'(e.mo3));
    check_value("w3_mealy_count", 32'(me3), 32'(e.me3));
    check_value("w3_mismatch", 32'(mism3), 32'(e.mo3 != e.me3));
    check_value("w3_saturated", 32'(sat3), 32'(e.sat3));
`ifdef DETECTION_COUNTER_FRAME_LEN_EN
    check_value("frame_len", 32'(frame_len), 32'(e.flen));
    check_value("w3_frame_len", 32'(flen3), 32'(e.flen3));
`endif
  endtask

  // Idle gap with stray Moore pulses that must not disturb the held counts.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b0; moore_detected = 1'b1; mealy_detected = 1'b0; report_ready = 1'b0;
      @(negedge clk);
    end
    moore_detected = 1'b0;
    check_value("idle_hold_moore", 32'(moore_count), 32'(last_e.mo));
    check_value("idle_hold_w3_moore", 32'(mo3), 32'(last_e.mo3));
  endtask

  task automatic run_frame(input int vlen, input int gap, input logic [63:0] mo_m,
                           input logic [63:0] me_m, input int hold, input int lost_at,
                           input logic exp_lost);
    int   cmo = 0;
    int   cme = 0;
    int   early = 0;
    int   waitc = 0;
    int   flen;
    exp_t e;
    for (int i = 0; i <= vlen + DRAIN; i++) begin
      data_valid     = (i < vlen) && (i != gap);
      moore_detected = mo_m[i];
      mealy_detected = me_m[i];
      if (mo_m[i]) cmo++;
      if (me_m[i]) cme++;
      @(negedge clk);
      if ((i < vlen + DRAIN) && report_valid) early++;
    end
    flen   = (gap >= 0) ? vlen - 1 : vlen;
    e.mo   = 16'(cmo);
    e.me   = 16'(cme);
    e.flen = 16'(flen);
    e.mism = (cmo != cme);
    e.sat  = (cmo > 65535) || (cme > 65535);
    e.lost = exp_lost;
    e.mo3  = (cmo > 7) ? 3'd7 : 3'(cmo);
    e.me3  = (cme > 7) ? 3'd7 : 3'(cme);
    e.flen3 = (flen > 7) ? 3'd7 : 3'(flen);
    e.sat3 = (cmo > 7) || (cme > 7);
`ifdef DETECTION_COUNTER_FRAME_LEN_EN
    e.sat  = e.sat || (flen > 65535);
    e.sat3 = e.sat3 || (flen > 7);
`endif
    exp_q.push_back(e);
    data_valid = 1'b0; moore_detected = 1'b0; mealy_detected = 1'b0;
    check_value("early_report_valid", 32'(early), 32'd0);
    check_value("report_latency", 32'(report_valid), 32'd1);
    while (!report_valid && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (!report_valid) check_value("report_timeout", 32'(report_valid), 32'd1);
    // Back-pressure: detections and optional burst during REPORT must not change the report.
    for (int h = 0; h < hold; h++) begin
      compare_report(exp_q[0]);
      data_valid = (h == lost_at); moore_detected = 1'b1; mealy_detected = 1'b1;
      @(negedge clk);
    end
    compare_report(exp_q[0]);
    data_valid = 1'b0; moore_detected = 1'b0; mealy_detected = 1'b0;
    report_ready = 1'b1;
    @(negedge clk);
    report_ready = 1'b0;
    check_value("report_accepted", 32'(report_valid), 32'd0);
    last_e = exp_q.pop_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_seen;
    reset = 1'b1; data_valid = 1'b0; moore_detected = 1'b0; mealy_detected = 1'b0;
    report_ready = 1'b0;
    last_e = '{default: '0};
    repeat (3) @(negedge clk);
    check_value("rst_report_valid", 32'(report_valid), 32'd0);
    check_value("rst_moore_count", 32'(moore_count), 32'd0);
    check_value("rst_mealy_count", 32'(mealy_count), 32'd0);
    check_value("rst_mismatch", 32'(mismatch), 32'd0);
    check_value("rst_saturated", 32'(saturated), 32'd0);
    check_value("rst_frame_lost", 32'(frame_lost), 32'd0);
    reset = 1'b0;
    idle_cycles(2);

    // 20-cycle frame, last Moore pulse one cycle after data_valid falls.
    run_frame(20, -1, (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 20),
              (64'd1 << 2) | (64'd1 << 11) | (64'd1 << 19), 0, -1, 1'b0);
    idle_cycles(3);
    // 2 vs 1 with report_ready held low for 5 cycles.
    run_frame(6, -1, (64'd1 << 1) | (64'd1 << 4), (64'd1 << 2), 5, -1, 1'b0);
    idle_cycles(2);
    // Nine Moore pulses starting on the frame-start cycle: saturates the 3-bit instance.
    run_frame(10, -1, 64'h1FF, 64'h1, 1, -1, 1'b0);
    idle_cycles(2);
    // One-cycle gap in data_valid, plus a burst while the report is pending.
    run_frame(8, 3, (64'd1 << 2) | (64'd1 << 5), (64'd1 << 3) | (64'd1 << 6), 2, 1, 1'b0);
    idle_cycles(3);
    run_frame(4, -1, (64'd1 << 1), (64'd1 << 1), 0, -1, 1'b1);
    idle_cycles(2);
    run_frame(3, -1, 64'd0, 64'd0, 0, -1, 1'b0);
    idle_cycles(2);

    // Reset in the middle of COUNT after four Moore pulses.
    for (int i = 0; i < 6; i++) begin
      data_valid = 1'b1; moore_detected = (i < 4); mealy_detected = (i == 0);
      @(negedge clk);
    end
    check_value("pre_reset_moore", 32'(moore_count), 32'd4);
    #2 reset = 1'b1;
    #1;
    check_value("midrst_report_valid", 32'(report_valid), 32'd0);
    check_value("midrst_moore_count", 32'(moore_count), 32'd0);
    check_value("midrst_mealy_count", 32'(mealy_count), 32'd0);
    check_value("midrst_mismatch", 32'(mismatch), 32'd0);
    check_value("midrst_saturated", 32'(saturated), 32'd0);
    check_value("midrst_frame_lost", 32'(frame_lost), 32'd0);
    data_valid = 1'b0; moore_detected = 1'b0; mealy_detected = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (report_valid) rv_seen++;
    end
    check_value("no_partial_report", 32'(rv_seen), 32'd0);
    check_value("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
